// File: rtl/uart_bus_bridge_pkg.sv
// Shared types and constants for the UART-driven bus initiator.
// Frame checksum support is enabled by UART_BUS_BRIDGE_CHKSUM_EN.
package uart_bus_bridge_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      CHK,
      BUS_WR,
      BUS_RD,
      TX_LOAD,
      TX_WAIT
   } state_t;

   localparam logic [7:0] CMD_WR   = 8'h57;
   localparam logic [7:0] CMD_RD   = 8'h52;
   localparam logic [7:0] NAK_BYTE = 8'h45;

   localparam int CNT_W = 2;

   function automatic logic [7:0] xor4(input logic [31:0] w);
      return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
   endfunction

endpackage

// File: rtl/uart_bus_bridge_if.sv
// UART byte and peripheral bus signals seen by the bridge.
// master = bridge side, slave = UART/peripheral environment side.
interface uart_bus_bridge_if;

   logic [7:0]  rx_data;
   logic        rx_status;
   logic [7:0]  tx_data;
   logic        tx_ctrl;
   logic        tx_status;
   logic        rd;
   logic        wr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        busy;
   logic        err;

   modport master (
      input  rx_data, rx_status, tx_status, rdata,
      output tx_data, tx_ctrl, rd, wr, addr, wdata, busy, err
   );

   modport slave (
      output rx_data, rx_status, tx_status, rdata,
      input  tx_data, tx_ctrl, rd, wr, addr, wdata, busy, err
   );

endinterface

// File: rtl/uart_bus_bridge_timeout.sv
// Inter-byte timeout counter: clr reloads zero, en lets it count,
// expired flags the last permitted cycle.
module bridge_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt;

   assign expired = en && (cnt == LAST);

   // count cycles since the last reload while enabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && !expired)
         cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command frames in, single-word peripheral bus accesses out.
// Define UART_BUS_BRIDGE_CHKSUM_EN for XOR-checksummed frames and replies.
module uart_bus_bridge
   import uart_bus_bridge_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000000,
   parameter logic [7:0]  ACK_BYTE       = 8'h4B
) (
   input  logic            clk,
   input  logic            reset,
   uart_bus_bridge_if.master bus
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               cmd_wr;
   logic [31:0]        tx_buf;
   logic [2:0]         rem;
   logic               tx_low;
   logic               tmr_clr;
   logic               tmr_en;
   logic               expired;
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
   logic [7:0]         csum;
`endif

   assign bus.busy = (state != IDLE);
   assign tmr_en   = (state inside {ADDR, DATA, CHK});
   assign tmr_clr  = bus.rx_status || !tmr_en;

   bridge_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_tmo (
      .clk     (clk),
      .reset   (reset),
      .clr     (tmr_clr),
      .en      (tmr_en),
      .expired (expired)
   );

   // frame decode, bus strobes and reply sequencing
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         cnt         <= '0;
         cmd_wr      <= 1'b0;
         tx_buf      <= '0;
         rem         <= '0;
         tx_low      <= 1'b0;
         bus.rd      <= 1'b0;
         bus.wr      <= 1'b0;
         bus.tx_ctrl <= 1'b0;
         bus.tx_data <= '0;
         bus.addr    <= '0;
         bus.wdata   <= '0;
         bus.err     <= 1'b0;
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
         csum        <= '0;
`endif
      end else begin
         bus.rd      <= 1'b0;
         bus.wr      <= 1'b0;
         bus.tx_ctrl <= 1'b0;
         if (bus.rx_status &&
             (state inside {BUS_WR, BUS_RD, TX_LOAD, TX_WAIT}))
            bus.err <= 1'b1;
         unique case (state)
            IDLE: begin
               if (bus.rx_status) begin
                  if (bus.rx_data == CMD_WR ||
                      bus.rx_data == CMD_RD) begin
                     cmd_wr <= (bus.rx_data == CMD_WR);
                     cnt    <= '0;
                     state  <= ADDR;
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
                     csum   <= bus.rx_data;
`endif
                  end else begin
                     bus.err <= 1'b1;
                  end
               end
            end
            ADDR: begin
               if (bus.rx_status) begin
                  bus.addr <= {bus.addr[23:0], bus.rx_data};
                  cnt      <= cnt + CNT_W'(1);
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
                  csum     <= csum ^ bus.rx_data;
                  if (cnt == CNT_W'(3))
                     state <= cmd_wr ? DATA : CHK;
`else
                  if (cnt == CNT_W'(3)) begin
                     if (cmd_wr) begin
                        state <= DATA;
                     end else begin
                        state  <= BUS_RD;
                        bus.rd <= 1'b1;
                     end
                  end
`endif
               end else if (expired) begin
                  state   <= IDLE;
                  bus.err <= 1'b1;
               end
            end
            DATA: begin
               if (bus.rx_status) begin
                  bus.wdata <= {bus.wdata[23:0], bus.rx_data};
                  cnt       <= cnt + CNT_W'(1);
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
                  csum      <= csum ^ bus.rx_data;
                  if (cnt == CNT_W'(3))
                     state <= CHK;
`else
                  if (cnt == CNT_W'(3)) begin
                     state  <= BUS_WR;
                     bus.wr <= 1'b1;
                  end
`endif
               end else if (expired) begin
                  state   <= IDLE;
                  bus.err <= 1'b1;
               end
            end
            CHK: begin
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
               if (bus.rx_status) begin
                  if (bus.rx_data == csum) begin
                     if (cmd_wr) begin
                        state  <= BUS_WR;
                        bus.wr <= 1'b1;
                     end else begin
                        state  <= BUS_RD;
                        bus.rd <= 1'b1;
                     end
                  end else begin
                     bus.tx_data <= NAK_BYTE;
                     rem         <= '0;
                     bus.err     <= 1'b1;
                     state       <= TX_LOAD;
                  end
               end else if (expired) begin
                  state   <= IDLE;
                  bus.err <= 1'b1;
               end
`else
               state <= IDLE;
`endif
            end
            BUS_WR: begin
               bus.tx_data <= ACK_BYTE;
               rem         <= '0;
               state       <= TX_LOAD;
            end
            BUS_RD: begin
               bus.tx_data <= bus.rdata[31:24];
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
               tx_buf      <= {bus.rdata[23:0], xor4(bus.rdata)};
               rem         <= 3'd4;
`else
               tx_buf      <= {bus.rdata[23:0], 8'h00};
               rem         <= 3'd3;
`endif
               state       <= TX_LOAD;
            end
            TX_LOAD: begin
               if (bus.tx_status) begin
                  bus.tx_ctrl <= 1'b1;
                  tx_low      <= 1'b0;
                  state       <= TX_WAIT;
               end
            end
            TX_WAIT: begin
               if (!bus.tx_status) begin
                  tx_low <= 1'b1;
               end else if (tx_low) begin
                  if (rem != '0) begin
                     bus.tx_data <= tx_buf[31:24];
                     tx_buf      <= tx_buf << 8;
                     rem         <= rem - 3'd1;
                     state       <= TX_LOAD;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Scoreboard bench for uart_bus_bridge: stimulus pushes expected bus
// accesses and reply bytes, a negedge monitor pops and compares them.
module tb_uart_bus_bridge;
   import uart_bus_bridge_pkg::*;

   localparam int K_WR = 0;
   localparam int K_RD = 1;
   localparam int K_TX = 2;

   typedef struct {
      int          kind;
      logic [31:0] a;
      logic [31:0] d;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] rdata_v = '0;
   int          total = 0;
   int          bad = 0;
   exp_t        q[$];

   uart_bus_bridge_if bif();

   assign bif.rdata = bif.rd ? rdata_v : 32'h0;

   uart_bus_bridge #(
      .TIMEOUT_CYCLES(100),
      .ACK_BYTE(8'h4B)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bif)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // monitor: every bus strobe or tx pulse must match the next expectation
   always @(negedge clk) begin
      if (reset) begin
         exp_t e;
         if (bif.rd && bif.wr)
            check("rd_wr_overlap", 1, 0);
         if (bif.wr || bif.rd || bif.tx_ctrl) begin
            if (q.size() == 0) begin
               check("unexpected_event", 1, 0);
            end else begin
               e = q.pop_front();
               if (bif.wr) begin
                  check("wr_kind", K_WR, e.kind);
                  check("wr_addr", bif.addr, e.a);
                  check("wr_data", bif.wdata, e.d);
               end else if (bif.rd) begin
                  check("rd_kind", K_RD, e.kind);
                  check("rd_addr", bif.addr, e.a);
               end else begin
                  check("tx_kind", K_TX, e.kind);
                  check("tx_ready", bif.tx_status, 1);
                  check("tx_byte", {24'h0, bif.tx_data}, e.d);
               end
            end
         end
      end
   end

   // transmitter model: goes busy after each start pulse, then idle again
   initial begin
      bif.tx_status = 1'b1;
      forever begin
         @(negedge clk);
         if (bif.tx_ctrl) begin
            @(posedge clk);
            #1 bif.tx_status = 1'b0;
            repeat (6) @(posedge clk);
            #1 bif.tx_status = 1'b1;
         end
      end
   end

   task automatic push(input int k, input logic [31:0] a,
                       input logic [31:0] d);
      exp_t e;
      e.kind = k;
      e.a = a;
      e.d = d;
      q.push_back(e);
   endtask

   task automatic send(input logic [7:0] b);
      @(posedge clk);
      #1;
      bif.rx_data = b;
      bif.rx_status = 1'b1;
      @(posedge clk);
      #1 bif.rx_status = 1'b0;
   endtask

   task automatic send_wr(input logic [31:0] a, input logic [31:0] d);
      logic [7:0] cs;
      cs = CMD_WR ^ xor4(a) ^ xor4(d);
      send(CMD_WR);
      for (int i = 3; i >= 0; i--) send(a[i*8 +: 8]);
      for (int i = 3; i >= 0; i--) send(d[i*8 +: 8]);
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
      send(cs);
`endif
   endtask

   task automatic send_rd(input logic [31:0] a);
      logic [7:0] cs;
      cs = CMD_RD ^ xor4(a);
      send(CMD_RD);
      for (int i = 3; i >= 0; i--) send(a[i*8 +: 8]);
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
      send(cs);
`endif
   endtask

   task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
      push(K_WR, a, d);
      push(K_TX, 0, 32'h4B);
   endtask

   task automatic exp_rd(input logic [31:0] a, input logic [31:0] v);
      push(K_RD, a, 0);
      for (int i = 3; i >= 0; i--) push(K_TX, 0, {24'h0, v[i*8 +: 8]});
`ifdef UART_BUS_BRIDGE_CHKSUM_EN
      push(K_TX, 0, {24'h0, xor4(v)});
`endif
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (!bif.busy) return;
      end
      check({name, "_idle_timeout"}, 1, 0);
   endtask

   task automatic do_reset();
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   initial begin
      bif.rx_data = '0;
      bif.rx_status = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_busy", bif.busy, 0);
      check("rst_err", bif.err, 0);
      check("rst_rd", bif.rd, 0);
      check("rst_wr", bif.wr, 0);
      check("rst_txctrl", bif.tx_ctrl, 0);
      check("rst_addr", bif.addr, 0);
      check("rst_wdata", bif.wdata, 0);
      check("rst_txdata", {24'h0, bif.tx_data}, 0);
      #1 reset = 1'b1;

      exp_wr(32'h10, 32'hDEADBEEF);
      send_wr(32'h10, 32'hDEADBEEF);
      check("wr_busy", bif.busy, 1);
      wait_idle("wr");
      check("wr_txst_at_idle", bif.tx_status, 1);
      check("wr_addr_hold", bif.addr, 32'h10);
      check("wr_wdata_hold", bif.wdata, 32'hDEADBEEF);
      check("wr_err", bif.err, 0);

      rdata_v = 32'h12345678;
      exp_rd(32'h20, 32'h12345678);
      send_rd(32'h20);
      wait_idle("rd");
      check("rd_addr_hold", bif.addr, 32'h20);
      check("rd_wdata_keep", bif.wdata, 32'hDEADBEEF);
      check("rd_err", bif.err, 0);

      send(8'h41);
      repeat (2) @(negedge clk);
      check("badcmd_err", bif.err, 1);
      check("badcmd_busy", bif.busy, 0);
      exp_wr(32'h30, 32'h11223344);
      send_wr(32'h30, 32'h11223344);
      wait_idle("after_bad");

      do_reset();
      send(CMD_WR);
      send(8'h00);
      repeat (50) @(negedge clk);
      check("tmo_busy_mid", bif.busy, 1);
      check("tmo_err_mid", bif.err, 0);
      repeat (60) @(negedge clk);
      check("tmo_busy", bif.busy, 0);
      check("tmo_err", bif.err, 1);
      rdata_v = 32'hCAFEF00D;
      exp_rd(32'h40, 32'hCAFEF00D);
      send_rd(32'h40);
      wait_idle("after_tmo");

      do_reset();
      rdata_v = 32'hA1B2C3D4;
      exp_rd(32'h50, 32'hA1B2C3D4);
      send_rd(32'h50);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bif.tx_ctrl) break;
      end
      repeat (2) @(posedge clk);
      send(8'h99);
      check("ovr_err", bif.err, 1);
      check("ovr_busy", bif.busy, 1);
      wait_idle("ovr");

      do_reset();
      send(CMD_WR);
      for (int i = 0; i < 4; i++) send(8'h00);
      send(8'hAA);
      send(8'hBB);
      #1 reset = 1'b0;
      #1;
      check("mid_rst_busy", bif.busy, 0);
      check("mid_rst_wr", bif.wr, 0);
      check("mid_rst_wdata", bif.wdata, 0);
      check("mid_rst_err", bif.err, 0);
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      exp_wr(32'h70, 32'h01020304);
      send_wr(32'h70, 32'h01020304);
      wait_idle("after_rst");
      check("after_rst_err", bif.err, 0);

`ifdef UART_BUS_BRIDGE_CHKSUM_EN
      push(K_TX, 0, {24'h0, NAK_BYTE});
      send(CMD_WR);
      for (int i = 0; i < 4; i++) send(8'h00);
      for (int i = 0; i < 4; i++) send(8'h11);
      send(8'h00);
      wait_idle("bad_chk");
      check("bad_chk_err", bif.err, 1);
`endif

      repeat (5) @(negedge clk);
      check("queue_empty", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_bus_bridge.md
Name: uart_bus_bridge

Overview:
- Bus initiator driven by UART bytes; the counterpart of the peripheral bus responder.
- Consumes received bytes from the UART byte interface and decodes read/write command frames from a host PC.
- Issues single-word rd/wr accesses on the 32-bit peripheral bus and returns an ack or the read data over the UART transmit byte interface.
- Used for host-side debug and loading of peripheral registers without CPU involvement.

Parameters:
- TIMEOUT_CYCLES, 1000000: maximum clk cycles allowed between bytes of one frame before the frame is aborted.
- ACK_BYTE, 8'h4B: byte returned after a completed write.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- rx_data  input  8  received byte; valid when rx_status=1.
- rx_status  input  1  one-cycle pulse: new byte on rx_data.
- tx_data  output  8  byte to transmit.
- tx_ctrl  output  1  one-cycle pulse: start transmitting tx_data.
- tx_status  input  1  level: 1 = transmitter idle/ready.
- rd  output  1  bus read strobe.
- wr  output  1  bus write strobe.
- addr  output  32  bus address.
- wdata  output  32  bus write data.
- rdata  input  32  bus read data; combinational, valid in the same cycle as rd.
- busy  output  1  1 whenever the state is not IDLE.
- err  output  1  sticky; set on timeout, unknown command or overrun; cleared only by reset.

Behaviour:
- Reset (async, reset=0): state=IDLE; rd, wr, tx_ctrl, busy, err=0; addr, wdata, tx_data=0; byte counter, rdata latch and timer cleared. Reset mid-frame or mid-transmit aborts immediately, with no bus access.
- Frame format:
  - Write: 'W' (8'h57), addr[31:24..7:0], data[31:24..7:0]. Nine bytes, MSB first.
  - Read: 'R' (8'h52), addr bytes MSB first. Five bytes.
- States and transitions:
  - IDLE: on rx_status with 'W' or 'R', latch the command and go to ADDR with byte count 0. Any other byte is discarded and sets err.
  - ADDR: each rx_status shifts addr left 8 and inserts rx_data. After the 4th byte go to DATA for 'W', or BUS_RD for 'R'.
  - DATA: shifts into wdata the same way. After the 4th byte go to BUS_WR.
  - BUS_WR: wr=1 for exactly one cycle with addr/wdata stable. Load tx_data=ACK_BYTE, then go to TX_LOAD.
  - BUS_RD: rd=1 for exactly one cycle. Latch rdata that cycle, set tx_data=rdata[31:24] with 4 bytes remaining, then go to TX_LOAD.
  - TX_LOAD: wait for tx_status=1, then pulse tx_ctrl for one cycle and go to TX_WAIT.
  - TX_WAIT: wait for tx_status to fall, then rise.
    - If bytes remain, load the next latched byte (MSB first) and return to TX_LOAD.
    - Otherwise go to IDLE.
- Bus output timing:
  - addr and wdata hold their values after the access until the next frame overwrites them.
  - rd and wr are never asserted together.
  - A Read frame produces no wr activity.
- Timeout: in ADDR or DATA, a free-running timer counts cycles since the last byte.
  - On reaching TIMEOUT_CYCLES-1: go to IDLE, set err, no bus access.
  - The timer is inactive in the bus and TX states.
- Overrun: an rx_status in BUS_WR, BUS_RD, TX_LOAD or TX_WAIT drops the byte and sets err. The state is unaffected.
- Latency: bus strobe is asserted in the cycle after the last frame byte's rx_status. tx_ctrl is asserted no earlier than one cycle after the strobe.

Optional Feature:
- Macro: UART_BUS_BRIDGE_CHKSUM_EN.
- Defined:
  - Each frame carries one extra trailing byte: XOR of all preceding frame bytes, including the command.
  - New state CHK follows the last addr byte (Read) or the last data byte (Write).
  - Match: proceed to BUS_RD or BUS_WR as normal.
  - Mismatch: no bus access; reply a single byte 8'h45 ('E'); set err.
  - Read replies append a 5th byte: XOR of the 4 data bytes.
- Undefined: no checksum byte in either direction; CHK state absent.

Decomposition:
- Package uart_bus_bridge_pkg:
  - State enum: IDLE, ADDR, DATA, CHK, BUS_WR, BUS_RD, TX_LOAD, TX_WAIT.
  - Command constants CMD_WR=8'h57, CMD_RD=8'h52, NAK_BYTE=8'h45.
  - Byte-count width.
- One sub-module, bridge_timeout: loadable inter-byte timeout counter with clear/enable inputs and an expired output.

Test Plan:
- Write frame 57 00 00 00 10 DE AD BE EF -> one-cycle wr with addr=32'h10, wdata=32'hDEADBEEF; then tx byte 4B; busy falls after tx_status rises.
- Read frame 52 00 00 00 20 with rdata=32'h12345678 -> one-cycle rd with addr=32'h20; tx bytes 12, 34, 56, 78 in order, each only after tx_status returns high.
- Byte 41 in IDLE -> err=1, no rd/wr, state stays IDLE; a following valid frame still completes.
- 57 00 then silence for TIMEOUT_CYCLES (set to 100) -> IDLE, err=1, no wr; a following read frame works.
- Extra rx_status during TX_WAIT -> byte dropped, err=1, remaining read bytes still sent correctly.
- Reset low during DATA after 2 data bytes -> all outputs 0 immediately, no wr; normal frame succeeds after release. With CHKSUM_EN, a bad checksum -> reply 45, no wr.
